// File: rtl/ad936x_cmos_framer_pkg.sv
// Shared types and helpers for the AD936x CMOS framer/deframer.
package ad936x_cmos_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    // Frame strobe expected on a slot: 1R1T marks only slot 0, wider modes mark slots 0 and 1.
    function automatic logic frame_bit(input int slot, input int num_ch);
        return (num_ch == 1) ? (slot == 0) : (slot < 2);
    endfunction

    function automatic int slot_w(input int p);
        return (p <= 2) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/ad936x_cmos_framer_tx.sv
// TX interleaver: free-running slot counter, per-frame sample latch, registered pins.
module ad936x_cmos_tx_framer
    import ad936x_cmos_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int NUM_CH = 2
) (
    input  logic                     rx_clk_in,
    input  logic                     rst,
    input  logic                     dac_valid,
    input  logic [NUM_CH*DATA_W-1:0] dac_data_i,
    input  logic [NUM_CH*DATA_W-1:0] dac_data_q,
    output logic                     dac_ready,
    output logic                     tx_underflow,
    output logic                     tx_frame_out,
    output logic [DATA_W-1:0]        tx_data_out
);

    localparam int P  = 2 * NUM_CH;
    localparam int SW = slot_w(P);

    logic [SW-1:0]              slot;
    logic [P-1:0][DATA_W-1:0]   frm;

    assign dac_ready = (slot == SW'(P - 1));

    always_ff @(posedge rx_clk_in or negedge rst) begin
        if (!rst) begin
            slot         <= '0;
            frm          <= '0;
            tx_underflow <= 1'b0;
            tx_frame_out <= 1'b0;
            tx_data_out  <= '0;
        end else begin
            tx_data_out  <= frm[slot];
            tx_frame_out <= frame_bit(int'(slot), NUM_CH);
            tx_underflow <= dac_ready & ~dac_valid;
            slot         <= dac_ready ? '0 : slot + SW'(1);
            // A missing sample set is sent as zeros so the frame cadence never breaks.
            if (dac_ready) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    frm[2*c]   <= dac_valid ? dac_data_i[c*DATA_W +: DATA_W] : '0;
                    frm[2*c+1] <= dac_valid ? dac_data_q[c*DATA_W +: DATA_W] : '0;
                end
            end
        end
    end

endmodule

// File: rtl/ad936x_cmos_framer.sv
// AD936x CMOS framer/deframer top: RX alignment/lock/deinterleave plus TX framer.
// Optional CMOS_LOOPBACK_EN adds loopback_en to feed RX from the TX pins internally.
module ad936x_cmos_framer
    import ad936x_cmos_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int NUM_CH      = 2,
    parameter int LOCK_FRAMES = 4,
    parameter int UNLOCK_ERRS = 3
) (
    input  logic                     rx_clk_in,
    input  logic                     rst,
`ifdef CMOS_LOOPBACK_EN
    input  logic                     loopback_en,
`endif
    input  logic                     rx_frame_in,
    input  logic [DATA_W-1:0]        rx_data_in,
    output logic                     adc_valid,
    output logic [NUM_CH*DATA_W-1:0] adc_data_i,
    output logic [NUM_CH*DATA_W-1:0] adc_data_q,
    output logic                     rx_status,
    output logic [15:0]              frame_err_cnt,
    input  logic                     dac_valid,
    input  logic [NUM_CH*DATA_W-1:0] dac_data_i,
    input  logic [NUM_CH*DATA_W-1:0] dac_data_q,
    output logic                     dac_ready,
    output logic                     tx_underflow,
    output logic                     tx_frame_out,
    output logic [DATA_W-1:0]        tx_data_out
);

    localparam int P  = 2 * NUM_CH;
    localparam int SW = slot_w(P);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(UNLOCK_ERRS + 1);

    rx_state_t                state, state_n;
    logic                     f_in, f_prev, lb_chg;
    logic [DATA_W-1:0]        d_in;
    logic [SW-1:0]            slot;
    logic [GW-1:0]            good_cnt;
    logic [BW-1:0]            bad_cnt;
    logic                     err_seen, mism, last, frame_bad, frame_ok, frame_ng;
    logic [P-1:0][DATA_W-1:0] shadow, frame_w;

    ad936x_cmos_tx_framer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) u_tx (
        .rx_clk_in    (rx_clk_in),
        .rst          (rst),
        .dac_valid    (dac_valid),
        .dac_data_i   (dac_data_i),
        .dac_data_q   (dac_data_q),
        .dac_ready    (dac_ready),
        .tx_underflow (tx_underflow),
        .tx_frame_out (tx_frame_out),
        .tx_data_out  (tx_data_out)
    );

`ifdef CMOS_LOOPBACK_EN
    logic lb_q;
    always_ff @(posedge rx_clk_in or negedge rst) begin
        if (!rst) lb_q <= 1'b0;
        else      lb_q <= loopback_en;
    end
    assign f_in   = lb_q ? tx_frame_out : rx_frame_in;
    assign d_in   = lb_q ? tx_data_out  : rx_data_in;
    assign lb_chg = (lb_q != loopback_en);
`else
    assign f_in   = rx_frame_in;
    assign d_in   = rx_data_in;
    assign lb_chg = 1'b0;
`endif

    assign mism      = (f_in != frame_bit(int'(slot), NUM_CH));
    assign last      = (slot == SW'(P - 1));
    assign frame_bad = err_seen | mism;

    always_comb begin
        frame_w        = shadow;
        frame_w[P-1]   = d_in;
    end

    always_ff @(posedge rx_clk_in or negedge rst) begin
        if (!rst) state <= SEARCH;
        else      state <= state_n;
    end

    always_comb begin
        state_n  = state;
        frame_ok = 1'b0;
        frame_ng = 1'b0;
        case (state)
            SEARCH: if (f_in && !f_prev) state_n = VERIFY;
            VERIFY: begin
                if (mism)
                    state_n = SEARCH;
                else if (last && good_cnt == GW'(LOCK_FRAMES - 1))
                    state_n = LOCKED;
            end
            LOCKED: begin
                if (last) begin
                    if (frame_bad) begin
                        frame_ng = 1'b1;
                        if (bad_cnt == BW'(UNLOCK_ERRS - 1)) state_n = SEARCH;
                    end else begin
                        frame_ok = 1'b1;
                    end
                end
            end
            default: state_n = SEARCH;
        endcase
        if (lb_chg) state_n = SEARCH;
    end

    always_ff @(posedge rx_clk_in or negedge rst) begin
        if (!rst) begin
            f_prev        <= 1'b0;
            slot          <= '0;
            good_cnt      <= '0;
            bad_cnt       <= '0;
            err_seen      <= 1'b0;
            shadow        <= '0;
            adc_valid     <= 1'b0;
            adc_data_i    <= '0;
            adc_data_q    <= '0;
            rx_status     <= 1'b0;
            frame_err_cnt <= '0;
        end else begin
            f_prev    <= f_in;
            adc_valid <= frame_ok;
            rx_status <= (state_n == LOCKED);
            if (state == SEARCH) begin
                bad_cnt <= '0;
                if (state_n == VERIFY) begin
                    shadow[0] <= d_in;
                    slot      <= SW'(1);
                    good_cnt  <= '0;
                    err_seen  <= 1'b0;
                end
            end else begin
                shadow[slot] <= d_in;
                slot         <= last ? '0 : slot + SW'(1);
                err_seen     <= last ? 1'b0 : frame_bad;
                if (state == VERIFY) begin
                    bad_cnt <= '0;
                    if (last && !mism) good_cnt <= good_cnt + GW'(1);
                end
                if (frame_ok) begin
                    bad_cnt <= '0;
                    for (int c = 0; c < NUM_CH; c++) begin
                        adc_data_i[c*DATA_W +: DATA_W] <= frame_w[2*c];
                        adc_data_q[c*DATA_W +: DATA_W] <= frame_w[2*c+1];
                    end
                end
                // Bad frames leave adc_data_* untouched; only the counters move.
                if (frame_ng) begin
                    bad_cnt <= bad_cnt + BW'(1);
                    if (frame_err_cnt != 16'hFFFF) frame_err_cnt <= frame_err_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ad936x_cmos_framer.sv
// Self-checking bench: frame-level RX model, queue-based TX model, 1R1T side instance.
module tb_ad936x_cmos_framer;

    localparam int W = 12;
    localparam int N = 2;
    localparam int P = 4;

    typedef logic [P-1:0][W-1:0] frame_t;
    typedef struct {
        bit bad;
        bit st;
        int err;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // main instance (2R2T)
    logic             lb = 1'b0, rf_drv = 1'b0;
    logic [W-1:0]     rd_drv = '0;
    logic             rx_frame;
    logic [W-1:0]     rx_data;
    logic             adc_valid, rx_status, dac_valid = 1'b0, dac_ready, tx_underflow, tx_frame_out;
    logic [N*W-1:0]   adc_data_i, adc_data_q, dac_data_i = '0, dac_data_q = '0;
    logic [15:0]      frame_err_cnt;
    logic [W-1:0]     tx_data_out;

    assign rx_frame = lb ? tx_frame_out : rf_drv;
    assign rx_data  = lb ? tx_data_out  : rd_drv;

    ad936x_cmos_framer #(.DATA_W(W), .NUM_CH(N), .LOCK_FRAMES(4), .UNLOCK_ERRS(3)) dut (
        .rx_clk_in(clk), .rst(rst), .rx_frame_in(rx_frame), .rx_data_in(rx_data),
        .adc_valid(adc_valid), .adc_data_i(adc_data_i), .adc_data_q(adc_data_q),
        .rx_status(rx_status), .frame_err_cnt(frame_err_cnt),
        .dac_valid(dac_valid), .dac_data_i(dac_data_i), .dac_data_q(dac_data_q),
        .dac_ready(dac_ready), .tx_underflow(tx_underflow),
        .tx_frame_out(tx_frame_out), .tx_data_out(tx_data_out));

    // side instance (1R1T) with a fixed 0xABC / 0x123 stream
    logic         f1 = 1'b0, v1, st1, rdy1, uf1, tf1;
    logic [W-1:0] d1 = '0, i1, q1, td1;
    logic [15:0]  ec1;

    ad936x_cmos_framer #(.DATA_W(W), .NUM_CH(1), .LOCK_FRAMES(4), .UNLOCK_ERRS(3)) dut1 (
        .rx_clk_in(clk), .rst(rst), .rx_frame_in(f1), .rx_data_in(d1),
        .adc_valid(v1), .adc_data_i(i1), .adc_data_q(q1),
        .rx_status(st1), .frame_err_cnt(ec1),
        .dac_valid(1'b0), .dac_data_i(12'h0), .dac_data_q(12'h0),
        .dac_ready(rdy1), .tx_underflow(uf1),
        .tx_frame_out(tf1), .tx_data_out(td1));

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // TX model state
    frame_t txq[$];
    bit     exp_uf, dac_rand, force_uf;
    int     t, inc_k;
    // RX model state
    bit           rlocked, pend, tbl_pend, tbl_st;
    int           rgcnt, rbcnt, rerr, tbl_err;
    logic [N*W-1:0] exp_i, exp_q;

    task automatic tick();
        frame_t fr;
        @(negedge clk);
        chk("tx_frame", tx_frame_out, (t % P) < 2);
        chk("tx_data", tx_data_out, txq[t / P][t % P]);
        chk("dac_ready", dac_ready, ((t + 1) % P) == P - 1);
        chk("tx_underflow", tx_underflow, exp_uf);
        exp_uf = 1'b0;
        if (((t + 1) % P) == P - 1) begin
            if (dac_rand) begin
                dac_valid  = force_uf ? 1'b0 : ($urandom % 4 != 0);
                dac_data_i = (N*W)'({$urandom, $urandom});
                dac_data_q = (N*W)'({$urandom, $urandom});
            end else begin
                dac_valid  = !force_uf;
                dac_data_i = {W'(1 + inc_k), W'(inc_k)};
                dac_data_q = {W'(1023 + inc_k), W'(1024 + inc_k)};
                inc_k++;
            end
            force_uf = 1'b0;
            for (int c = 0; c < N; c++) begin
                fr[2*c]   = dac_valid ? dac_data_i[c*W +: W] : '0;
                fr[2*c+1] = dac_valid ? dac_data_q[c*W +: W] : '0;
            end
            txq.push_back(fr);
            exp_uf = !dac_valid;
        end else begin
            dac_valid  = $urandom % 2;
            dac_data_i = (N*W)'({$urandom, $urandom});
            dac_data_q = (N*W)'({$urandom, $urandom});
        end
        // 1R1T: locks after 4 frames, then a valid pulse every 2 cycles
        chk("u1_status", st1, t >= 8);
        chk("u1_valid", v1, (t >= 10) && (t % 2 == 0));
        if (t >= 10) begin
            chk("u1_data_i", i1, 12'hABC);
            chk("u1_data_q", q1, 12'h123);
        end
        f1 = (t % 2 == 0);
        d1 = (t % 2 == 0) ? 12'hABC : 12'h123;
        t++;
    endtask

    task automatic rx_check();
        chk("adc_valid_end", adc_valid, pend);
        pend = 1'b0;
        chk("rx_status", rx_status, rlocked);
        chk("frame_err_cnt", frame_err_cnt, 16'(rerr));
        chk("adc_data_i", adc_data_i, exp_i);
        chk("adc_data_q", adc_data_q, exp_q);
        if (tbl_pend) begin
            chk("tbl_status", rx_status, tbl_st);
            chk("tbl_err", frame_err_cnt, 16'(tbl_err));
            tbl_pend = 1'b0;
        end
    endtask

    // One frame on the RX pins (or from TX in loopback); bad = slot-0 strobe held low.
    task automatic send_frame(input bit bad, input bit use_lb);
        frame_t w;
        int k;
        k = t / P;
        for (int s = 0; s < P; s++) begin
            tick();
            if (s == 0) begin
                lb = use_lb;
                rx_check();
            end else begin
                chk("adc_valid_mid", adc_valid, 1'b0);
            end
            if (!use_lb) begin
                w[s]   = W'($urandom);
                rf_drv = (s < 2) && !(bad && s == 0);
                rd_drv = w[s];
            end
        end
        if (use_lb) w = txq[k];
        if (rlocked) begin
            if (!bad) begin
                pend  = 1'b1;
                rbcnt = 0;
                for (int c = 0; c < N; c++) begin
                    exp_i[c*W +: W] = w[2*c];
                    exp_q[c*W +: W] = w[2*c+1];
                end
            end else begin
                if (rerr < 16'hFFFF) rerr++;
                rbcnt++;
                if (rbcnt == 3) begin
                    rlocked = 1'b0;
                    rgcnt   = 0;
                end
            end
        end else if (bad) begin
            rgcnt = 0;
        end else begin
            rgcnt++;
            if (rgcnt == 4) rlocked = 1'b1;
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_adc_valid"}, adc_valid, 1'b0);
        chk({nm, "_adc_i"}, adc_data_i, '0);
        chk({nm, "_adc_q"}, adc_data_q, '0);
        chk({nm, "_status"}, rx_status, 1'b0);
        chk({nm, "_errcnt"}, frame_err_cnt, 16'h0);
        chk({nm, "_dac_ready"}, dac_ready, 1'b0);
        chk({nm, "_underflow"}, tx_underflow, 1'b0);
        chk({nm, "_tx_frame"}, tx_frame_out, 1'b0);
        chk({nm, "_tx_data"}, tx_data_out, '0);
        chk({nm, "_u1_valid"}, v1, 1'b0);
        chk({nm, "_u1_status"}, st1, 1'b0);
    endtask

    task automatic do_reset(input bit mid);
        if (mid) begin
            @(posedge clk);
            #2 rst = 1'b0;
        end else begin
            rst = 1'b0;
        end
        #1 chk_zero(mid ? "rst_mid" : "rst");
        rf_drv = 1'b0; rd_drv = '0; f1 = 1'b0; d1 = '0;
        txq.delete();
        txq.push_back('0);
        t = 0; exp_uf = 0; force_uf = 0; inc_k = 0;
        rlocked = 0; pend = 0; tbl_pend = 0; rgcnt = 0; rbcnt = 0; rerr = 0;
        exp_i = '0; exp_q = '0;
        repeat (2) @(negedge clk);
        chk_zero("rst_hold");
        rst = 1'b1;
    endtask

    row_t tbl[12];

    initial begin
        // starting LOCKED with no errors
        tbl[0]  = '{1, 1, 1};
        tbl[1]  = '{0, 1, 1};
        tbl[2]  = '{1, 1, 2};
        tbl[3]  = '{1, 1, 3};
        tbl[4]  = '{1, 0, 4};
        tbl[5]  = '{0, 0, 4};
        tbl[6]  = '{1, 0, 4};
        tbl[7]  = '{0, 0, 4};
        tbl[8]  = '{0, 0, 4};
        tbl[9]  = '{0, 0, 4};
        tbl[10] = '{0, 1, 4};
        tbl[11] = '{0, 1, 4};

        do_reset(0);

        // external loopback, incrementing TX samples
        dac_rand = 0;
        repeat (10) send_frame(0, 1);

        // pin-driven error / unlock / relock sequence
        foreach (tbl[r]) begin
            send_frame(tbl[r].bad, 0);
            tbl_pend = 1'b1;
            tbl_st   = tbl[r].st;
            tbl_err  = tbl[r].err;
        end

        // randomized frames, one forced TX underflow then random ones
        dac_rand = 1;
        force_uf = 1;
        repeat (40) send_frame($urandom % 4 == 0, 0);

        // loopback relock, then reset in the middle of a frame
        repeat (6) send_frame(0, 1);
        tick();
        tick();
        do_reset(1);
        dac_rand = 0;
        repeat (8) send_frame(0, 1);
        chk("relock_status", rx_status, 1'b1);
        send_frame(0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
